// File: rtl/logic_gates_bist_ctrl.sv
// Self-test sequencer for the 2-input logic_gates unit: sweeps a/b, samples y, counts mismatches.
// Optional first-failure log enabled by defining LGBIST_ERR_LOG_EN.
module logic_gates_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             gate_a,
  output logic             gate_b,
  input  logic [6:0]       gate_y,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count
`ifdef LGBIST_ERR_LOG_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_y
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected y for vector v (a = v[1], b = v[0]).
  function automatic logic [6:0] golden_y(input logic [1:0] v);
    case (v)
      2'd0:    golden_y = 7'h6C;
      2'd1:    golden_y = 7'h56;
      2'd2:    golden_y = 7'h16;
      2'd3:    golden_y = 7'h23;
      default: golden_y = 7'h00;
    endcase
  endfunction

  state_t          state_r, state_s;
  logic [1:0]      vec_r, vec_s;
  logic [PW-1:0]   pass_idx_r, pass_idx_s;
  logic [SW-1:0]   settle_cnt_r, settle_cnt_s;
  logic [CNT_W-1:0] fail_count_s;
  logic            busy_s, done_s, result_valid_s, pass_s, gate_a_s, gate_b_s;
  logic            mismatch_s;
`ifdef LGBIST_ERR_LOG_EN
  logic            ff_valid_s;
  logic [1:0]      ff_vec_s;
  logic [6:0]      ff_y_s;
`endif

  // Next-state and next-output decode; abort overrides every state.
  always_comb begin
    state_s        = state_r;
    vec_s          = vec_r;
    pass_idx_s     = pass_idx_r;
    settle_cnt_s   = settle_cnt_r;
    fail_count_s   = fail_count;
    result_valid_s = result_valid;
    pass_s         = pass;
    done_s         = 1'b0;
    mismatch_s     = (gate_y != golden_y(vec_r));
`ifdef LGBIST_ERR_LOG_EN
    ff_valid_s     = first_fail_valid;
    ff_vec_s       = first_fail_vec;
    ff_y_s         = first_fail_y;
`endif
    if (abort) begin
      state_s        = ST_IDLE;
      result_valid_s = 1'b0;
      pass_s         = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s        = ST_SETTLE;
            vec_s          = 2'd0;
            pass_idx_s     = '0;
            settle_cnt_s   = '0;
            fail_count_s   = '0;
            result_valid_s = 1'b0;
            pass_s         = 1'b0;
`ifdef LGBIST_ERR_LOG_EN
            ff_valid_s     = 1'b0;
            ff_vec_s       = 2'd0;
            ff_y_s         = 7'h00;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_s      = ST_CHECK;
            settle_cnt_s = '0;
          end else begin
            settle_cnt_s = settle_cnt_r + SW'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch_s && (fail_count != CNT_MAX)) begin
            fail_count_s = fail_count + CNT_W'(1);
          end else begin
            fail_count_s = fail_count;
          end
`ifdef LGBIST_ERR_LOG_EN
          if (mismatch_s && !first_fail_valid) begin
            ff_valid_s = 1'b1;
            ff_vec_s   = vec_r;
            ff_y_s     = gate_y;
          end else begin
            ff_valid_s = first_fail_valid;
          end
`endif
          if (vec_r != 2'd3) begin
            vec_s   = vec_r + 2'd1;
            state_s = ST_SETTLE;
          end else if (pass_idx_r != PASS_LAST) begin
            vec_s      = 2'd0;
            pass_idx_s = pass_idx_r + PW'(1);
            state_s    = ST_SETTLE;
          end else begin
            state_s        = ST_DONE;
            done_s         = 1'b1;
            result_valid_s = 1'b1;
            pass_s         = (fail_count_s == '0);
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s   = (state_s == ST_SETTLE) || (state_s == ST_CHECK);
    gate_a_s = busy_s ? vec_s[1] : 1'b0;
    gate_b_s = busy_s ? vec_s[0] : 1'b0;
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      vec_r        <= 2'd0;
      pass_idx_r   <= '0;
      settle_cnt_r <= '0;
      fail_count   <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      gate_a       <= 1'b0;
      gate_b       <= 1'b0;
    end else begin
      state_r      <= state_s;
      vec_r        <= vec_s;
      pass_idx_r   <= pass_idx_s;
      settle_cnt_r <= settle_cnt_s;
      fail_count   <= fail_count_s;
      result_valid <= result_valid_s;
      pass         <= pass_s;
      done         <= done_s;
      busy         <= busy_s;
      gate_a       <= gate_a_s;
      gate_b       <= gate_b_s;
    end
  end

`ifdef LGBIST_ERR_LOG_EN
  // First-failure log registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 2'd0;
      first_fail_y     <= 7'h00;
    end else begin
      first_fail_valid <= ff_valid_s;
      first_fail_vec   <= ff_vec_s;
      first_fail_y     <= ff_y_s;
    end
  end
`endif

endmodule
